// File: rtl/dso_dac_pkg.sv
// rtl/dso_dac_pkg.sv - shared types and DAC command-word format for the trigger-level DAC path
package dso_dac_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

    localparam int WORD_CH_BIT     = 15;
    localparam int WORD_BUF_BIT    = 14;
    localparam int WORD_GA_N_BIT   = 13;
    localparam int WORD_SHDN_N_BIT = 12;
    localparam int WORD_LEVEL_W    = 12;

    localparam logic BUF_VAL    = 1'b0;
    localparam logic GA_N_VAL   = 1'b1;
    localparam logic SHDN_N_VAL = 1'b1;

    // Assemble a 16-bit DAC command word from channel and 12-bit level
    function automatic logic [15:0] make_word(input chan_t ch, input logic [WORD_LEVEL_W-1:0] lvl);
        logic [15:0] w;
        w                  = 16'h0000;
        w[WORD_CH_BIT]     = (ch == CH_B);
        w[WORD_BUF_BIT]    = BUF_VAL;
        w[WORD_GA_N_BIT]   = GA_N_VAL;
        w[WORD_SHDN_N_BIT] = SHDN_N_VAL;
        w[WORD_LEVEL_W-1:0] = lvl;
        return w;
    endfunction

endpackage

// File: rtl/trigger_dac_scheduler.sv
// rtl/trigger_dac_scheduler.sv - shadowed trigger levels, round-robin DAC frame issue with gap, refresh and watchdog
module trigger_dac_scheduler
    import dso_dac_pkg::*;
#(
    parameter int DATA_W         = 12,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] level_a,
    input  logic [DATA_W-1:0] level_b,
    input  logic [1:0]        level_we,
    output logic [15:0]       dac_word,
    output logic              dac_start,
    input  logic              dac_done,
    output logic              busy,
    output logic [1:0]        pending,
    output logic              timeout_err
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    chan_t              last_ch;
    chan_t              next_ch;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shadow_a;
    logic [DATA_W-1:0]  shadow_b;
    logic [DATA_W-1:0]  lvl_sel;
    logic [1:0]         pend_set;
    logic [1:0]         pend_clr;
    logic               refresh_hit;

    // Free-running refresh timer; its wrap re-arms both channels
    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            localparam int RW = $clog2(REFRESH_CYCLES + 1);
            logic [RW-1:0] rcnt;

            // Count 0..REFRESH_CYCLES-1 and wrap
            always_ff @(posedge clk) begin
                if (reset) begin
                    rcnt <= '0;
                end else if (rcnt == RW'(REFRESH_CYCLES - 1)) begin
                    rcnt <= '0;
                end else begin
                    rcnt <= rcnt + RW'(1);
                end
            end

            assign refresh_hit = (rcnt == RW'(REFRESH_CYCLES - 1));
        end else begin : g_no_refresh
            assign refresh_hit = 1'b0;
        end
    endgenerate

    // Round-robin choice and the level to snapshot; a write landing in the
    // selecting cycle is forwarded so it is not lost when pending clears
    always_comb begin
        next_ch = CH_A;
        if (pending == 2'b11) begin
            next_ch = (last_ch == CH_A) ? CH_B : CH_A;
        end else if (pending[1] && !pending[0]) begin
            next_ch = CH_B;
        end
        if (next_ch == CH_A) begin
            lvl_sel = level_we[0] ? level_a : shadow_a;
        end else begin
            lvl_sel = level_we[1] ? level_b : shadow_b;
        end
        pend_set = level_we | {2{refresh_hit}};
        pend_clr = 2'b00;
        if (state == LOAD) begin
            pend_clr = (last_ch == CH_B) ? 2'b10 : 2'b01;
        end
    end

    // Shadow registers and pending flags; a new request wins over the LOAD clear
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_a <= '0;
            shadow_b <= '0;
            pending  <= 2'b00;
        end else begin
            if (level_we[0]) shadow_a <= level_a;
            if (level_we[1]) shadow_b <= level_b;
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    // Frame sequencer; one down-counter serves as watchdog and gap timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_ch     <= CH_B;
            cnt         <= '0;
            dac_word    <= 16'h0000;
            dac_start   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            dac_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending != 2'b00) begin
                        state     <= LOAD;
                        last_ch   <= next_ch;
                        dac_word  <= make_word(next_ch, WORD_LEVEL_W'(lvl_sel));
                        dac_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= WAIT_DONE;
                    cnt   <= CNT_W'(TIMEOUT_CYCLES - 1);
                end
                WAIT_DONE: begin
                    if (dac_done) begin
                        state <= GAP;
                        cnt   <= CNT_W'(GAP_CYCLES - 1);
                    end else if (cnt == '0) begin
                        timeout_err <= 1'b1;
                        state       <= GAP;
                        cnt         <= CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_dac_scheduler.sv
// tb/tb_trigger_dac_scheduler.sv - directed self-checking bench for trigger_dac_scheduler
module tb_trigger_dac_scheduler;

    logic        clk;
    logic        reset;
    logic [11:0] level_a, level_b;
    logic [1:0]  level_we;
    logic [15:0] dac_word;
    logic        dac_start;
    logic        dac_done;
    logic        busy;
    logic [1:0]  pending;
    logic        timeout_err;

    logic        reset_r;
    logic [11:0] level_a_r, level_b_r;
    logic [1:0]  level_we_r;
    logic [15:0] dac_word_r;
    logic        dac_start_r;
    logic        dac_done_r;
    logic        busy_r;
    logic [1:0]  pending_r;
    logic        timeout_err_r;

    int n_cmp;
    int n_bad;
    int cyc;
    bit auto_done;
    int done_dly;

    logic [15:0] start_q[$];
    int          startc_q[$];
    int          done_q[$];
    logic [15:0] r_start_q[$];
    int          r_startc_q[$];

    trigger_dac_scheduler #(
        .DATA_W(12), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64), .REFRESH_CYCLES(0)
    ) dut (
        .clk(clk), .reset(reset), .level_a(level_a), .level_b(level_b),
        .level_we(level_we), .dac_word(dac_word), .dac_start(dac_start),
        .dac_done(dac_done), .busy(busy), .pending(pending), .timeout_err(timeout_err)
    );

    trigger_dac_scheduler #(
        .DATA_W(12), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64), .REFRESH_CYCLES(100)
    ) dut_r (
        .clk(clk), .reset(reset_r), .level_a(level_a_r), .level_b(level_b_r),
        .level_we(level_we_r), .dac_word(dac_word_r), .dac_start(dac_start_r),
        .dac_done(dac_done_r), .busy(busy_r), .pending(pending_r), .timeout_err(timeout_err_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // frame monitor for both instances
    initial begin
        forever begin
            @(negedge clk);
            if (dac_start) begin
                start_q.push_back(dac_word);
                startc_q.push_back(cyc);
            end
            if (dac_start_r) begin
                r_start_q.push_back(dac_word_r);
                r_startc_q.push_back(cyc);
            end
        end
    end

    // SPI stage model for the main instance
    initial begin
        dac_done = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_start && auto_done) begin
                repeat (done_dly) @(negedge clk);
                dac_done = 1'b1;
                done_q.push_back(cyc);
                @(negedge clk);
                dac_done = 1'b0;
            end
        end
    end

    // SPI stage model for the refresh instance
    initial begin
        dac_done_r = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_start_r) begin
                repeat (2) @(negedge clk);
                dac_done_r = 1'b1;
                @(negedge clk);
                dac_done_r = 1'b0;
            end
        end
    end

    task automatic wait_start();
        int n;
        n = 0;
        while (!dac_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("start_wait", {31'd0, dac_start}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || pending != 2'b00) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {29'd0, busy, pending}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_q();
        start_q.delete();
        startc_q.delete();
        done_q.delete();
    endtask

    initial begin
        int n0;
        int n;
        n_cmp = 0;
        n_bad = 0;
        auto_done = 1'b1;
        done_dly = 3;
        reset = 1'b1;
        level_a = 12'h000;
        level_b = 12'h000;
        level_we = 2'b00;
        reset_r = 1'b1;
        level_a_r = 12'h000;
        level_b_r = 12'h000;
        level_we_r = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        reset_r = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_word", {16'd0, dac_word}, 32'h0);
        check("rst_start", {31'd0, dac_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pending", {30'd0, pending}, 32'd0);
        check("rst_err", {31'd0, timeout_err}, 32'd0);

        // single A write: pending at N+1, start at N+2
        level_a = 12'hABC;
        level_we = 2'b01;
        @(negedge clk);
        level_we = 2'b00;
        check("t1_pending", {30'd0, pending}, 32'h1);
        @(negedge clk);
        check("t1_start", {31'd0, dac_start}, 32'd1);
        check("t1_word", {16'd0, dac_word}, 32'h3ABC);
        @(negedge clk);
        check("t1_pend_clr", {30'd0, pending}, 32'h0);
        check("t1_start_1cyc", {31'd0, dac_start}, 32'd0);
        wait_idle();

        // simultaneous A/B after reset: A first, then B after gap
        pulse_reset();
        clear_q();
        level_a = 12'h100;
        level_b = 12'h200;
        level_we = 2'b11;
        @(negedge clk);
        level_we = 2'b00;
        wait_idle();
        check("t2_nframes", start_q.size(), 32'd2);
        check("t2_word0", {16'd0, start_q[0]}, 32'h3100);
        check("t2_word1", {16'd0, start_q[1]}, 32'hB200);
        check("t2_gap", startc_q[1] - done_q[0], 32'd6);

        // coalesced B writes during an in-flight A frame
        clear_q();
        done_dly = 10;
        level_a = 12'h055;
        level_we = 2'b01;
        @(negedge clk);
        level_we = 2'b00;
        wait_start();
        @(negedge clk);
        level_b = 12'h001;
        level_we = 2'b10;
        @(negedge clk);
        level_b = 12'h002;
        @(negedge clk);
        level_b = 12'h003;
        @(negedge clk);
        level_we = 2'b00;
        check("t3_inflight_word", {16'd0, dac_word}, 32'h3055);
        check("t3_pending", {30'd0, pending}, 32'h2);
        wait_idle();
        check("t3_nframes", start_q.size(), 32'd2);
        check("t3_bword", {16'd0, start_q[1]}, 32'hB003);
        done_dly = 3;

        // write coinciding with LOAD of the same channel
        clear_q();
        level_a = 12'h111;
        level_we = 2'b01;
        @(negedge clk);
        level_we = 2'b00;
        @(negedge clk);
        check("t4_load_word", {16'd0, dac_word}, 32'h3111);
        level_a = 12'h222;
        level_we = 2'b01;
        @(negedge clk);
        level_we = 2'b00;
        check("t4_pend_kept", {30'd0, pending}, 32'h1);
        wait_idle();
        check("t4_nframes", start_q.size(), 32'd2);
        check("t4_word1", {16'd0, start_q[1]}, 32'h3222);

        // watchdog: done withheld
        clear_q();
        auto_done = 1'b0;
        level_b = 12'h0AA;
        level_we = 2'b10;
        @(negedge clk);
        level_we = 2'b00;
        wait_start();
        @(negedge clk);
        level_a = 12'h0CC;
        level_we = 2'b01;
        @(negedge clk);
        level_we = 2'b00;
        repeat (62) @(negedge clk);
        check("t5_err_before", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        check("t5_err_after", {31'd0, timeout_err}, 32'd1);
        check("t5_busy_gap", {31'd0, busy}, 32'd1);
        auto_done = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_next_start", {31'd0, dac_start}, 32'd1);
        check("t5_next_word", {16'd0, dac_word}, 32'h30CC);
        wait_idle();
        check("t5_err_sticky", {31'd0, timeout_err}, 32'd1);

        // reset during WAIT_DONE discards everything
        auto_done = 1'b0;
        level_a = 12'h001;
        level_b = 12'h002;
        level_we = 2'b11;
        @(negedge clk);
        level_we = 2'b00;
        wait_start();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_word", {16'd0, dac_word}, 32'h0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_pending", {30'd0, pending}, 32'h0);
        check("t6_err", {31'd0, timeout_err}, 32'd0);
        n0 = start_q.size();
        repeat (100) @(negedge clk);
        check("t6_no_frames", start_q.size(), n0);
        check("t6_busy_after", {31'd0, busy}, 32'd0);

        // periodic refresh on the second instance
        n = 0;
        while (r_start_q.size() < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t7_nframes", {31'd0, r_start_q.size() >= 4}, 32'd1);
        check("t7_word0", {16'd0, r_start_q[0]}, 32'h3000);
        check("t7_word1", {16'd0, r_start_q[1]}, 32'hB000);
        check("t7_word2", {16'd0, r_start_q[2]}, 32'h3000);
        check("t7_word3", {16'd0, r_start_q[3]}, 32'hB000);
        check("t7_period", r_startc_q[2] - r_startc_q[0], 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
